modesel_luma16x16: RTL

Intra 16x16 luma mode decision block. It consumes the vertical, horizontal and DC predictions from the luma 16x16 predictor row by row, together with the matching original macroblock rows. It accumulates a sum of absolute differences (SAD) per mode over 16 rows and reports the lowest-cost mode and its SAD to the encoder control. It sits directly downstream of the predictor and upstream of residual/transform.

---
 rtl/intra_pkg.sv | 10 +
 rtl/sad_row.sv | 22 ++
 rtl/modesel_luma16x16.sv | 101 ++++++++++
 3 files changed

// File: rtl/intra_pkg.sv
// intra_pkg: shared intra-prediction mode encodings, mode-decision state type and block defaults
package intra_pkg;
  localparam int PIX_W = 8;
  localparam int BLK = 16;
  localparam int SAD_W = 16;
  localparam logic [1:0] MODE_V = 2'd0;
  localparam logic [1:0] MODE_H = 2'd1;
  localparam logic [1:0] MODE_DC = 2'd2;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_COMPARE, ST_DONE} state_t;
endpackage

// File: rtl/sad_row.sv
// sad_row: combinational sum of absolute differences across one row of pixels
module sad_row #(
  parameter int PIX_W = intra_pkg::PIX_W,
  parameter int BLK = intra_pkg::BLK,
  parameter int ROW_W = PIX_W + $clog2(BLK)
) (
  input  logic [BLK*PIX_W-1:0] a_i,
  input  logic [BLK*PIX_W-1:0] b_i,
  output logic [ROW_W-1:0]     sad_o
);
  logic [PIX_W-1:0] ad [BLK];
  for (genvar i = 0; i < BLK; i++) begin : g_pix
    logic signed [PIX_W:0] d;
    assign d = $signed({1'b0, a_i[i*PIX_W +: PIX_W]}) - $signed({1'b0, b_i[i*PIX_W +: PIX_W]});
    assign ad[i] = d[PIX_W] ? PIX_W'(-d) : PIX_W'(d);
  end
  // sum the per-pixel magnitudes; synthesis balances this into a tree
  always_comb begin
    sad_o = '0;
    for (int i = 0; i < BLK; i++) sad_o = sad_o + ROW_W'(ad[i]);
  end
endmodule

// File: rtl/modesel_luma16x16.sv
// modesel_luma16x16: accumulates per-mode SAD over a 16x16 luma block and picks the cheapest intra mode
module modesel_luma16x16 #(
  parameter int PIX_W = intra_pkg::PIX_W,
  parameter int BLK = intra_pkg::BLK,
  parameter int SAD_W = intra_pkg::SAD_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 row_valid,
  output logic                 row_ready,
  input  logic [BLK*PIX_W-1:0] orig_row,
  input  logic [BLK*PIX_W-1:0] vpred_row,
  input  logic [BLK*PIX_W-1:0] hpred_row,
  input  logic [BLK*PIX_W-1:0] dcpred_row,
  output logic                 busy,
  output logic                 done,
  output logic [1:0]           best_mode,
  output logic [SAD_W-1:0]     best_sad,
  output logic [SAD_W-1:0]     sad_v,
  output logic [SAD_W-1:0]     sad_h,
  output logic [SAD_W-1:0]     sad_dc
);
  import intra_pkg::*;
  localparam int ROW_W = PIX_W + $clog2(BLK);
  localparam int CNT_W = $clog2(BLK);
  state_t state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [SAD_W-1:0] acc_v_q, acc_h_q, acc_dc_q, acc_v_d, acc_h_d, acc_dc_d;
  logic [SAD_W-1:0] best_sad_q, best_sad_d, sad_v_q, sad_h_q, sad_dc_q, sad_vh;
  logic [1:0] best_mode_q, best_mode_d, mode_vh;
  logic busy_q, done_q, row_ready_q;
  logic [ROW_W-1:0] rs_v, rs_h, rs_dc;
  sad_row #(.PIX_W(PIX_W), .BLK(BLK), .ROW_W(ROW_W)) u_sad_v (.a_i(orig_row), .b_i(vpred_row), .sad_o(rs_v));
  sad_row #(.PIX_W(PIX_W), .BLK(BLK), .ROW_W(ROW_W)) u_sad_h (.a_i(orig_row), .b_i(hpred_row), .sad_o(rs_h));
  sad_row #(.PIX_W(PIX_W), .BLK(BLK), .ROW_W(ROW_W)) u_sad_dc (.a_i(orig_row), .b_i(dcpred_row), .sad_o(rs_dc));
  // next accumulator values and the strict-less-than winner with V > H > DC on ties
  always_comb begin
    acc_v_d = acc_v_q + SAD_W'(rs_v);
    acc_h_d = acc_h_q + SAD_W'(rs_h);
    acc_dc_d = acc_dc_q + SAD_W'(rs_dc);
    mode_vh = (acc_h_q < acc_v_q) ? MODE_H : MODE_V;
    sad_vh = (acc_h_q < acc_v_q) ? acc_h_q : acc_v_q;
    best_mode_d = (acc_dc_q < sad_vh) ? MODE_DC : mode_vh;
    best_sad_d = (acc_dc_q < sad_vh) ? acc_dc_q : sad_vh;
  end
  // control FSM with registered handshake/status outputs and the held result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      {acc_v_q, acc_h_q, acc_dc_q} <= '0;
      {best_mode_q, best_sad_q, sad_v_q, sad_h_q, sad_dc_q} <= '0;
      {busy_q, done_q, row_ready_q} <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          state_q <= ST_ACCUM;
          cnt_q <= '0;
          {acc_v_q, acc_h_q, acc_dc_q} <= '0;
          {best_mode_q, best_sad_q, sad_v_q, sad_h_q, sad_dc_q} <= '0;
          busy_q <= 1'b1;
          row_ready_q <= 1'b1;
        end
        ST_ACCUM: if (row_valid && row_ready_q) begin
          acc_v_q <= acc_v_d;
          acc_h_q <= acc_h_d;
          acc_dc_q <= acc_dc_d;
          cnt_q <= (cnt_q == CNT_W'(BLK - 1)) ? '0 : cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BLK - 1)) begin
            state_q <= ST_COMPARE;
            row_ready_q <= 1'b0;
          end
        end
        ST_COMPARE: begin
          best_mode_q <= best_mode_d;
          best_sad_q <= best_sad_d;
          sad_v_q <= acc_v_q;
          sad_h_q <= acc_h_q;
          sad_dc_q <= acc_dc_q;
          done_q <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign row_ready = row_ready_q;
  assign best_mode = best_mode_q;
  assign best_sad = best_sad_q;
  assign sad_v = sad_v_q;
  assign sad_h = sad_h_q;
  assign sad_dc = sad_dc_q;
endmodule
